fsm_txrspmux: RTL
=================

Name: fsm_txrspmux

Overview:
Collects read-back responses from the MODULES_CNT register modules addressed by the RX command pipeline. Serialises them into the TX FIFO as two-word frames: a header word, then a data word. One capture slot per module; round-robin arbitration between pending slots; the TX FIFO full flag provides backpressure. Sits between the module array and the TX FIFO write port, mirroring the RX command parser on the return path.

Parameters:
FIFO_DATA_WIDTH, 32, width of TX FIFO words and response data
CMD_OUTPUT_WIDTH, 5, width of the echoed command field
MODULE_SELECT_WIDTH, 5, width of the module id field (ids 1..MODULES_CNT; 0 is invalid)
MODULES_CNT, 19, number of responding modules
CNT_WIDTH, 16, width of the sent-frame counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
i_rsp_valid  in  MODULES_CNT  per-module response request; held high until acked
i_rsp_data  in  MODULES_CNT x FIFO_DATA_WIDTH  per-module response data
i_rsp_cmd  in  MODULES_CNT x CMD_OUTPUT_WIDTH  per-module echoed command code
o_rsp_ack  out  MODULES_CNT  one-cycle pulse: slot captured
o_tx_data  out  FIFO_DATA_WIDTH  TX FIFO write data
o_tx_wr_en  out  1  TX FIFO write enable
i_tx_full  in  1  TX FIFO full
o_busy  out  1  high when any slot is pending or a frame is in flight
o_frame_cnt  out  CNT_WIDTH  frames completed; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst low, async): state IDLE; all pending flags 0; all slot registers 0; rr_last = MODULES_CNT-1; o_rsp_ack 0; o_frame_cnt 0; o_busy 0; o_tx_wr_en 0; o_tx_data 0.
- Capture: at an edge where i_rsp_valid[k]=1 and pending[k]=0:
  - data[k] and cmd[k] are latched and pending[k] is set.
  - o_rsp_ack[k]=1 for exactly the following cycle.
  - A slot is never re-captured while pending; a valid held high during pending produces no further ack.
  - The module drops valid after seeing the ack.
- A slot cleared at edge t is capturable at edge t+1 at the earliest; there is no same-edge reuse.
- Arbitration (sub-module rr_arbiter):
  - Among pending slots, pick the first index after rr_last, cyclically.
  - rr_last is updated to the granted index on grant.
  - Grant happens in IDLE when any slot is pending, or at completion of DATA when another slot is pending.
- FSM states: IDLE, HDR, DATA.
  - IDLE -> HDR on grant of slot g.
  - HDR -> DATA when the header word is written.
  - DATA -> HDR (next grant) or IDLE when the data word is written.
  - On the DATA write: pending[g] cleared and o_frame_cnt incremented.
- Writes: o_tx_wr_en = (state==HDR or DATA) and not i_tx_full (combinational from registered state).
  - A word is transferred on an edge with o_tx_wr_en=1.
  - While i_tx_full=1 the state holds and o_tx_data stays stable.
- Header word layout:
  - bit0 = 1 (response marker)
  - [MODULE_SELECT_WIDTH:1] = g+1
  - [MODULE_SELECT_WIDTH+CMD_OUTPUT_WIDTH:MODULE_SELECT_WIDTH+1] = cmd[g]
  - all higher bits 0
- Data word = data[g]. o_tx_data = 0 in IDLE.
- Back-to-back frames: no idle cycle between frames when slots are pending and the FIFO is not full.
- Latency: valid at edge t with tx not full gives: capture t, grant t+1, header written t+2, data written t+3.
- Simultaneous capture of several slots on one edge is allowed; each gets its own ack pulse.
- Reset mid-frame: async clear per the reset list.
  - A header already written without its data remains in the TX FIFO; host software flushes it.
  - The module side re-issues its response after reset.

Decomposition:
- Package fsm_txrspmux_pkg:
  - state enum (IDLE, HDR, DATA)
  - header field offsets: RSP_MARK_BIT=0, ID_LSB=1, CMD_LSB=MODULE_SELECT_WIDTH+1
  - function building the header word from id and cmd
- Sub-module rr_arbiter: inputs are the pending vector, rr_last and an enable; outputs are the grant valid and the grant index. Purely combinational pick; the rr_last register stays in the parent.

Test Plan:
- Single response: i_rsp_valid[2]=1, data 0xDEADBEEF, cmd 5, tx not full -> o_rsp_ack[2] one cycle after capture; TX writes 0x00000147 then 0xDEADBEEF on consecutive cycles; o_frame_cnt=1; o_busy returns to 0.
- Simultaneous valids on 0, 4 and 18 after reset -> frames in order id 1, 5, 19, in six consecutive wr_en cycles. Then with 0 and 5 pending after serving 4 -> 5 served before 0.
- i_tx_full high for 3 cycles while in DATA -> o_tx_wr_en=0 for those 3 cycles; o_tx_data is held; the data word is written on the first non-full cycle; no duplicates.
- Module 7 holds valid for 10 cycles -> exactly one o_rsp_ack[7] pulse and one frame.
- Assert rst low after the header of slot 3 is written -> all outputs 0 asynchronously; pending cleared; o_frame_cnt=0. After release, a new request on slot 3 produces a complete frame.
- Frame counter wrap: with CNT_WIDTH=4, send 17 frames -> o_frame_cnt=1.

Source files
------------

// File: rtl/fsm_txrspmux_pkg.sv
// Shared types and header-word layout for the TX response multiplexer.
// The header builder works on a wide word so callers can size fields by parameter.
package fsm_txrspmux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int MODULE_SELECT_WIDTH_DEF = 5;
    localparam int RSP_MARK_BIT            = 0;
    localparam int ID_LSB                  = 1;
    localparam int CMD_LSB                 = MODULE_SELECT_WIDTH_DEF + 1;
    localparam int HDR_MAX_W               = 64;

    // id and cmd must arrive zero-extended to their field widths
    function automatic logic [HDR_MAX_W-1:0] build_header(
        input logic [HDR_MAX_W-1:0] id,
        input logic [HDR_MAX_W-1:0] cmd,
        input int                   cmd_lsb
    );
        return (HDR_MAX_W'(1'b1) << RSP_MARK_BIT) | (id << ID_LSB) | (cmd << cmd_lsb);
    endfunction

endpackage

// File: rtl/fsm_txrspmux_rr_arbiter.sv
// Combinational round-robin pick: first pending index after rr_last, cyclically.
// The rr_last register is owned by the parent.
module fsm_txrspmux_rr_arbiter #(
    parameter int N     = 19,
    parameter int IDX_W = 5
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] rr_last,
    input  logic             en,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] cand_s;

    // scan from rr_last+1 around to rr_last, keep the first hit
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand_s    = '0;
        for (int i = 1; i <= N; i++) begin
            cand_s = IDX_W'((int'(rr_last) + i) % N);
            if (en && !gnt_valid && pending[cand_s]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_s;
            end else begin
                gnt_idx   = gnt_idx;
            end
        end
    end

endmodule

// File: rtl/fsm_txrspmux.sv
// Captures per-module read-back responses and serialises them into the TX FIFO
// as header/data frames with round-robin arbitration and full-flag backpressure.
module fsm_txrspmux
    import fsm_txrspmux_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH     = 32,
    parameter int CMD_OUTPUT_WIDTH    = 5,
    parameter int MODULE_SELECT_WIDTH = 5,
    parameter int MODULES_CNT         = 19,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [MODULES_CNT-1:0]                   i_rsp_valid,
    input  logic [MODULES_CNT*FIFO_DATA_WIDTH-1:0]   i_rsp_data,
    input  logic [MODULES_CNT*CMD_OUTPUT_WIDTH-1:0]  i_rsp_cmd,
    output logic [MODULES_CNT-1:0]                   o_rsp_ack,
    output logic [FIFO_DATA_WIDTH-1:0]               o_tx_data,
    output logic                                     o_tx_wr_en,
    input  logic                                     i_tx_full,
    output logic                                     o_busy,
    output logic [CNT_WIDTH-1:0]                     o_frame_cnt
);

    localparam int IDX_W = (MODULES_CNT > 1) ? $clog2(MODULES_CNT) : 1;

    state_t                       state_r;
    logic [IDX_W-1:0]             gnt_r;
    logic [IDX_W-1:0]             rr_last_r;
    logic [MODULES_CNT-1:0]       pending_r;
    logic [MODULES_CNT-1:0]       ack_r;
    logic [FIFO_DATA_WIDTH-1:0]   data_r [MODULES_CNT];
    logic [CMD_OUTPUT_WIDTH-1:0]  cmd_r  [MODULES_CNT];
    logic [FIFO_DATA_WIDTH-1:0]   tx_data_r;
    logic                         busy_r;
    logic [CNT_WIDTH-1:0]         frame_cnt_r;

    logic                         wr_en_s;
    logic                         done_s;
    logic                         arb_en_s;
    logic [MODULES_CNT-1:0]       capture_s;
    logic [MODULES_CNT-1:0]       clear_s;
    logic [MODULES_CNT-1:0]       pending_nxt_s;
    logic [MODULES_CNT-1:0]       arb_pend_s;
    logic                         gnt_valid_s;
    logic [IDX_W-1:0]             gnt_idx_s;

    function automatic logic [FIFO_DATA_WIDTH-1:0] hdr_word(
        input logic [IDX_W-1:0]            idx,
        input logic [CMD_OUTPUT_WIDTH-1:0] cmd
    );
        logic [MODULE_SELECT_WIDTH-1:0] id;
        id = MODULE_SELECT_WIDTH'(idx) + MODULE_SELECT_WIDTH'(1'b1);
        return FIFO_DATA_WIDTH'(build_header(HDR_MAX_W'(id), HDR_MAX_W'(cmd),
                                             MODULE_SELECT_WIDTH + ID_LSB));
    endfunction

    // write strobe, frame completion and slot bookkeeping for the coming edge
    always_comb begin
        wr_en_s  = ((state_r == ST_HDR) || (state_r == ST_DATA)) && !i_tx_full;
        done_s   = (state_r == ST_DATA) && wr_en_s;
        arb_en_s = (state_r == ST_IDLE) || done_s;
        if (done_s) begin
            clear_s = MODULES_CNT'(1'b1) << gnt_r;
        end else begin
            clear_s = '0;
        end
        capture_s     = i_rsp_valid & ~pending_r;
        pending_nxt_s = (pending_r | capture_s) & ~clear_s;
        // the slot finishing now must not win the follow-on grant
        arb_pend_s    = pending_r & ~clear_s;
    end

    fsm_txrspmux_rr_arbiter #(
        .N     (MODULES_CNT),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .pending   (arb_pend_s),
        .rr_last   (rr_last_r),
        .en        (arb_en_s),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // per-slot capture registers, pending flags and ack pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= '0;
            ack_r     <= '0;
            for (int k = 0; k < MODULES_CNT; k++) begin
                data_r[k] <= '0;
                cmd_r[k]  <= '0;
            end
        end else begin
            pending_r <= pending_nxt_s;
            ack_r     <= capture_s;
            for (int k = 0; k < MODULES_CNT; k++) begin
                if (capture_s[k]) begin
                    data_r[k] <= i_rsp_data[k*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
                    cmd_r[k]  <= i_rsp_cmd[k*CMD_OUTPUT_WIDTH +: CMD_OUTPUT_WIDTH];
                end
            end
        end
    end

    // frame sequencer: header then data per grant, holding while the FIFO is full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            gnt_r       <= '0;
            rr_last_r   <= IDX_W'(MODULES_CNT - 1);
            tx_data_r   <= '0;
            busy_r      <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            busy_r <= |pending_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_valid_s) begin
                        state_r   <= ST_HDR;
                        gnt_r     <= gnt_idx_s;
                        rr_last_r <= gnt_idx_s;
                        tx_data_r <= hdr_word(gnt_idx_s, cmd_r[gnt_idx_s]);
                    end else begin
                        tx_data_r <= '0;
                    end
                end
                ST_HDR: begin
                    if (wr_en_s) begin
                        state_r   <= ST_DATA;
                        tx_data_r <= data_r[gnt_r];
                    end
                end
                ST_DATA: begin
                    if (wr_en_s) begin
                        frame_cnt_r <= frame_cnt_r + CNT_WIDTH'(1'b1);
                        if (gnt_valid_s) begin
                            state_r   <= ST_HDR;
                            gnt_r     <= gnt_idx_s;
                            rr_last_r <= gnt_idx_s;
                            tx_data_r <= hdr_word(gnt_idx_s, cmd_r[gnt_idx_s]);
                        end else begin
                            state_r   <= ST_IDLE;
                            tx_data_r <= '0;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    tx_data_r <= '0;
                end
            endcase
        end
    end

    assign o_rsp_ack   = ack_r;
    assign o_tx_data   = tx_data_r;
    assign o_tx_wr_en  = wr_en_s;
    assign o_busy      = busy_r;
    assign o_frame_cnt = frame_cnt_r;

endmodule
